// File: rtl/ifu_if.sv
// Fetch-side bundle between the instruction fetch unit and its neighbours.
// Carries the run/stall/jump controls, the program-memory request/response
// pair and the instruction handed to the decoder. master = fetch unit side.
interface ifu_if #(
  parameter int PC_WIDTH = 10
);
  // control from execute / decoder
  logic                i_enable;
  logic                i_stall;
  logic                i_jump;
  logic [PC_WIDTH-1:0] i_jump_addr;
  // program memory
  logic [PC_WIDTH-1:0] o_pmem_addr;
  logic                o_pmem_re;
  logic [15:0]         i_pmem_data;
  logic                i_pmem_valid;
  // to decoder
  logic [15:0]         o_instruction;
  logic                o_instruction_valid;
  logic [PC_WIDTH-1:0] o_pc;

  modport master (
    input  i_enable, i_stall, i_jump, i_jump_addr, i_pmem_data, i_pmem_valid,
    output o_pmem_addr, o_pmem_re, o_instruction, o_instruction_valid, o_pc
  );

  modport slave (
    output i_enable, i_stall, i_jump, i_jump_addr, i_pmem_data, i_pmem_valid,
    input  o_pmem_addr, o_pmem_re, o_instruction, o_instruction_valid, o_pc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one program-memory read at a
//   time and presents the returned 16-bit instruction to the decoder.
// Latency: request -> instruction valid is memory latency + 1 cycle.
// Backpressure: i_stall holds the presented instruction; no new read is
//   issued until it is consumed. Jumps take priority over everything.
// Ports: i_clk, i_rst_n (async active-low) plus the ifu_if master bundle.
module ifu #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic    i_clk,
  input logic    i_rst_n,
  ifu_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  state_t              run_state;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] inst_pc, inst_pc_nxt;
  logic [15:0]         inst, inst_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      inst_pc <= '0;
      inst    <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      inst_pc <= inst_pc_nxt;
      inst    <= inst_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_pc_nxt = inst_pc;
    inst_nxt    = inst;
    // where to go once the current fetch (if any) is finished with
    run_state   = bus.i_enable ? REQ : IDLE;

    case (state)
      IDLE: state_nxt = run_state;
      // a read issued this cycle is in flight even if we get redirected
      REQ:  state_nxt = bus.i_jump ? FLUSH : WAIT;
      WAIT: begin
        if (bus.i_jump) begin
          // returning data belongs to the old path; if it is here already
          // there is nothing left to flush
          state_nxt = bus.i_pmem_valid ? run_state : FLUSH;
        end else if (bus.i_pmem_valid) begin
          inst_nxt    = bus.i_pmem_data;
          inst_pc_nxt = pc;
          pc_nxt      = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          state_nxt   = HOLD;
        end
      end
      FLUSH: begin
        if (bus.i_pmem_valid) state_nxt = run_state;
      end
      // a jump kills the held instruction just like a consume would end it
      HOLD: begin
        if (bus.i_jump || !bus.i_stall) state_nxt = run_state;
      end
      default: state_nxt = IDLE;
    endcase

    // redirect overrides the sequential increment in every state
    if (bus.i_jump) pc_nxt = bus.i_jump_addr;
  end

  assign bus.o_pmem_re           = (state == REQ);
  assign bus.o_pmem_addr         = pc;
  assign bus.o_instruction       = inst;
  assign bus.o_instruction_valid = (state == HOLD);
  assign bus.o_pc                = inst_pc;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  // memory model controls
  int          lat;
  logic        mem_clear;
  logic        model_valid;
  logic [15:0] model_data;
  logic        man_valid;
  logic [15:0] man_data;

  ifu_if #(.PC_WIDTH(10)) bus ();

  ifu #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.i_pmem_valid = model_valid | man_valid;
  assign bus.i_pmem_data  = man_valid ? man_data : model_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // program memory: mem[a] = 16'h1000 + a, valid 'lat' cycles after the strobe
  initial begin
    int          cnt;
    logic [9:0]  req_addr;
    cnt         = 0;
    req_addr    = '0;
    model_valid = 1'b0;
    model_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_clear) begin
        cnt         = 0;
        model_valid = 1'b0;
      end else begin
        model_valid = 1'b0;
        if (cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            model_valid = 1'b1;
            model_data  = 16'h1000 + {6'b0, req_addr};
          end
        end
        if (bus.o_pmem_re === 1'b1) begin
          req_addr = bus.o_pmem_addr;
          cnt      = lat;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.o_instruction_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, {31'b0, bus.o_instruction_valid}, 32'd1);
  endtask

  task automatic wait_re(input string tag);
    int n;
    n = 0;
    while (bus.o_pmem_re !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_re_seen"}, {31'b0, bus.o_pmem_re}, 32'd1);
  endtask

  initial begin
    int prev_cyc;
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    prev_cyc      = 0;
    lat           = 1;
    mem_clear     = 1'b1;
    man_valid     = 1'b0;
    man_data      = '0;
    rst_n         = 1'b0;
    bus.i_enable  = 1'b0;
    bus.i_stall   = 1'b0;
    bus.i_jump    = 1'b0;
    bus.i_jump_addr = '0;

    // reset state
    step();
    step();
    chk("rst_re",    {31'b0, bus.o_pmem_re}, 32'd0);
    chk("rst_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
    chk("rst_instr", {16'b0, bus.o_instruction}, 32'h0);
    chk("rst_pc",    {22'b0, bus.o_pc}, 32'h0);
    chk("rst_addr",  {22'b0, bus.o_pmem_addr}, 32'h0);

    // sequential fetch, latency 1
    rst_n        = 1'b1;
    mem_clear    = 1'b0;
    bus.i_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid("seq");
      if (k > 0) chk("seq_gap", cyc - prev_cyc, 32'd3);
      prev_cyc = cyc;
      chk("seq_pc",    {22'b0, bus.o_pc}, k);
      chk("seq_instr", {16'b0, bus.o_instruction}, 32'h1000 + k);
      step();
      chk("seq_pulse", {31'b0, bus.o_instruction_valid}, 32'd0);
    end
    wait_valid("pc4");
    chk("pc4_pc", {22'b0, bus.o_pc}, 32'd4);
    step();

    // stall on pc 5 for 4 cycles
    wait_valid("stall");
    chk("stall_pc", {22'b0, bus.o_pc}, 32'd5);
    bus.i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.i_stall = 1'b0;
      chk("stall_valid", {31'b0, bus.o_instruction_valid}, 32'd1);
      chk("stall_instr", {16'b0, bus.o_instruction}, 32'h1005);
      chk("stall_re",    {31'b0, bus.o_pmem_re}, 32'd0);
      if (i < 4) step();
    end
    step();
    chk("stall_after_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
    chk("stall_after_re",    {31'b0, bus.o_pmem_re}, 32'd1);
    chk("stall_after_addr",  {22'b0, bus.o_pmem_addr}, 32'd6);

    // jump during WAIT, latency 3
    lat = 3;
    wait_valid("pc6");
    chk("pc6_pc", {22'b0, bus.o_pc}, 32'd6);
    step();
    chk("pc7_re",   {31'b0, bus.o_pmem_re}, 32'd1);
    chk("pc7_addr", {22'b0, bus.o_pmem_addr}, 32'd7);
    step();
    bus.i_jump      = 1'b1;
    bus.i_jump_addr = 10'h200;
    step();
    bus.i_jump = 1'b0;
    chk("jw_flush_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
    wait_re("jw");
    chk("jw_addr", {22'b0, bus.o_pmem_addr}, 32'h200);
    wait_valid("jw");
    chk("jw_pc",    {22'b0, bus.o_pc}, 32'h200);
    chk("jw_instr", {16'b0, bus.o_instruction}, 32'h1200);

    // jump in HOLD while stalled
    bus.i_stall = 1'b1;
    step();
    chk("jh_held_valid", {31'b0, bus.o_instruction_valid}, 32'd1);
    chk("jh_held_instr", {16'b0, bus.o_instruction}, 32'h1200);
    bus.i_jump      = 1'b1;
    bus.i_jump_addr = 10'h0AA;
    lat             = 1;
    step();
    bus.i_jump  = 1'b0;
    bus.i_stall = 1'b0;
    chk("jh_kill_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
    chk("jh_re",         {31'b0, bus.o_pmem_re}, 32'd1);
    chk("jh_addr",       {22'b0, bus.o_pmem_addr}, 32'h0AA);
    wait_valid("jh");
    chk("jh_pc",    {22'b0, bus.o_pc}, 32'h0AA);
    chk("jh_instr", {16'b0, bus.o_instruction}, 32'h10AA);

    // wrap-around
    bus.i_jump      = 1'b1;
    bus.i_jump_addr = 10'h3FF;
    step();
    bus.i_jump = 1'b0;
    chk("wrap_re",   {31'b0, bus.o_pmem_re}, 32'd1);
    chk("wrap_addr", {22'b0, bus.o_pmem_addr}, 32'h3FF);
    wait_valid("wrap_a");
    chk("wrap_pc_a",    {22'b0, bus.o_pc}, 32'h3FF);
    chk("wrap_instr_a", {16'b0, bus.o_instruction}, 32'h13FF);
    step();
    wait_valid("wrap_b");
    chk("wrap_pc_b",    {22'b0, bus.o_pc}, 32'h000);
    chk("wrap_instr_b", {16'b0, bus.o_instruction}, 32'h1000);

    // enable dropped in WAIT
    step();
    chk("en_re",   {31'b0, bus.o_pmem_re}, 32'd1);
    chk("en_addr", {22'b0, bus.o_pmem_addr}, 32'd1);
    step();
    bus.i_enable = 1'b0;
    step();
    chk("en_valid", {31'b0, bus.o_instruction_valid}, 32'd1);
    chk("en_pc",    {22'b0, bus.o_pc}, 32'd1);
    chk("en_instr", {16'b0, bus.o_instruction}, 32'h1001);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en_idle_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
      chk("en_idle_re",    {31'b0, bus.o_pmem_re}, 32'd0);
    end

    // reset in WAIT, late valid ignored
    lat          = 3;
    bus.i_enable = 1'b1;
    step();
    chk("rw_re",   {31'b0, bus.o_pmem_re}, 32'd1);
    chk("rw_addr", {22'b0, bus.o_pmem_addr}, 32'd2);
    step();
    chk("rw_wait_re", {31'b0, bus.o_pmem_re}, 32'd0);
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    lat       = 1;
    #1;
    chk("rw_rst_re",    {31'b0, bus.o_pmem_re}, 32'd0);
    chk("rw_rst_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
    chk("rw_rst_instr", {16'b0, bus.o_instruction}, 32'h0);
    chk("rw_rst_pc",    {22'b0, bus.o_pc}, 32'h0);
    chk("rw_rst_addr",  {22'b0, bus.o_pmem_addr}, 32'h0);
    step();
    rst_n     = 1'b1;
    mem_clear = 1'b0;
    man_valid = 1'b1;
    man_data  = 16'hDEAD;
    step();
    man_valid = 1'b0;
    chk("rw_req_re",    {31'b0, bus.o_pmem_re}, 32'd1);
    chk("rw_req_addr",  {22'b0, bus.o_pmem_addr}, 32'd0);
    chk("rw_req_valid", {31'b0, bus.o_instruction_valid}, 32'd0);
    wait_valid("rw");
    chk("rw_pc",    {22'b0, bus.o_pc}, 32'd0);
    chk("rw_instr", {16'b0, bus.o_instruction}, 32'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
